// File: rtl/axi_interconnect_crossbar_sreq_arbit.sv
// ============================================================================
// Module   : axi_interconnect_crossbar_sreq_arbit
// Purpose  : Request-side arbiter for one slave port of the AXI crossbar.
//            Shares the slave's AR or AW address channel between NUM_MASTER
//            requesters. Each accepted request goes through a registered
//            output stage. In the same cycle its routing tag is pushed into
//            the slave's response-ordering queue. In-flight transactions are
//            limited to NUM_OUTSTANDING.
// Config   : define AXI_IC_SREQ_FIXED_PRIO_EN for fixed priority, where the
//            lowest master index wins. Left undefined (the default), the
//            arbiter is round-robin.
// Ports    : clk_sys, rst_n       - clock, asynchronous active-low reset
//            m_req_info/id/valid  - packed per-master request channels (in)
//            m_req_ready          - one-hot grant to masters (out)
//            s_req_info/id/valid  - registered request to slave (out)
//            s_req_ready          - slave accept (in)
//            req_wren, req_id     - response-ordering queue push {onehot, ID}
//            resp_done            - one pulse per completed transaction (in)
//            outstanding_cnt      - current in-flight count (out)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_interconnect_crossbar_sreq_arbit #(
    parameter int NUM_MASTER        = 2,
    parameter int WIDTH_ID          = 4,
    parameter int WIDTH_REQINFO     = 64,
    parameter int NUM_OUTSTANDING   = 4,
    parameter int WIDTH_OUTSTANDING = $clog2(NUM_OUTSTANDING),
    parameter int U_DLY             = 1
) (
    input  logic                              clk_sys,
    input  logic                              rst_n,
    input  logic [NUM_MASTER*WIDTH_REQINFO-1:0] m_req_info,
    input  logic [NUM_MASTER*WIDTH_ID-1:0]    m_req_id,
    input  logic [NUM_MASTER-1:0]             m_req_valid,
    output logic [NUM_MASTER-1:0]             m_req_ready,
    output logic [WIDTH_REQINFO-1:0]          s_req_info,
    output logic [WIDTH_ID-1:0]               s_req_id,
    output logic                              s_req_valid,
    input  logic                              s_req_ready,
    output logic                              req_wren,
    output logic [NUM_MASTER+WIDTH_ID-1:0]    req_id,
    input  logic                              resp_done,
    output logic [WIDTH_OUTSTANDING:0]        outstanding_cnt
);

    localparam int c_WG = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1;
    localparam int c_WC = WIDTH_OUTSTANDING + 1;
    localparam logic [c_WC-1:0] c_CNT_ONE = c_WC'(1);
    localparam logic [c_WC-1:0] c_CNT_MAX = c_WC'(NUM_OUTSTANDING);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Registers update with zero delay. U_DLY only takes part in this
    // parameter range check; out-of-range configurations are unsupported.
    generate
        if (NUM_MASTER < 1 || NUM_MASTER > 4 || NUM_OUTSTANDING < 1 ||
            NUM_OUTSTANDING > 16 || WIDTH_ID < 1 || U_DLY < 0) begin : g_param_unsupported
        end
    endgenerate

    state_t                       state_q, state_d;
    logic [c_WC-1:0]              cnt_q, cnt_d;
    logic [WIDTH_REQINFO-1:0]     s_info_q;
    logic [WIDTH_ID-1:0]          s_id_q;
    logic                         req_wren_q;
    logic [NUM_MASTER+WIDTH_ID-1:0] req_id_q;

    logic [c_WG-1:0]              w_win_idx;
    logic                         w_win_found;
    logic [NUM_MASTER-1:0]        w_win_oh;
    logic [WIDTH_REQINFO-1:0]     w_sel_info;
    logic [WIDTH_ID-1:0]          w_sel_id;
    logic                         w_credit_ok;
    logic                         w_grant;
    logic                         w_dec;

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
`ifdef AXI_IC_SREQ_FIXED_PRIO_EN
    // Scan from the highest index down so that the lowest valid index is
    // the last one written and therefore wins.
    always_comb begin
        w_win_idx   = '0;
        w_win_found = 1'b0;
        for (int i = NUM_MASTER - 1; i >= 0; i--) begin
            if (m_req_valid[i[c_WG-1:0]]) begin
                w_win_idx   = i[c_WG-1:0];
                w_win_found = 1'b1;
            end
        end
    end
`else
    logic [c_WG-1:0] last_grant_q;

    // The search starts one past the previous winner. Because
    // last_grant_q resets to NUM_MASTER-1, master 0 is first after reset.
    always_comb begin
        int idx;
        idx         = 0;
        w_win_idx   = '0;
        w_win_found = 1'b0;
        for (int k = 1; k <= NUM_MASTER; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_MASTER;
            if (!w_win_found && m_req_valid[idx[c_WG-1:0]]) begin
                w_win_idx   = idx[c_WG-1:0];
                w_win_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= c_WG'(NUM_MASTER - 1);
        end else if (w_grant) begin
            last_grant_q <= w_win_idx;
        end
    end
`endif

    // One-hot of the winner and the payload/ID mux for its slice.
    always_comb begin
        w_win_oh   = '0;
        w_sel_info = '0;
        w_sel_id   = '0;
        for (int i = 0; i < NUM_MASTER; i++) begin
            if (w_win_idx == i[c_WG-1:0]) begin
                w_win_oh[i] = 1'b1;
                w_sel_info  = m_req_info[i*WIDTH_REQINFO +: WIDTH_REQINFO];
                w_sel_id    = m_req_id[i*WIDTH_ID +: WIDTH_ID];
            end
        end
    end

    // Credit is judged on the registered count. A resp_done in this cycle
    // therefore frees a slot only from the next cycle on. rst_n gates the
    // grant so that m_req_ready stays low while reset is held.
    assign w_credit_ok = (cnt_q < c_CNT_MAX);
    assign w_grant     = rst_n && (state_q == ST_IDLE) && w_credit_ok && w_win_found;
    assign m_req_ready = w_grant ? w_win_oh : '0;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_grant)     state_d = ST_SEND;
            ST_SEND: if (s_req_ready) state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outstanding counter: a resp_done at zero is dropped, so the count
    // saturates at 0. The grant gate keeps the count from passing the limit.
    // ------------------------------------------------------------------
    assign w_dec = resp_done && (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        case ({w_grant, w_dec})
            2'b10:   cnt_d = cnt_q + c_CNT_ONE;
            2'b01:   cnt_d = cnt_q - c_CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Output register and queue push. The payload is sampled only in the
    // grant cycle and then held for the whole SEND phase. req_wren rises
    // together with s_req_valid, so the queue entry exists before the
    // slave can answer.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            s_info_q   <= '0;
            s_id_q     <= '0;
            req_wren_q <= 1'b0;
            req_id_q   <= '0;
            cnt_q      <= '0;
        end else begin
            req_wren_q <= w_grant;
            cnt_q      <= cnt_d;
            if (w_grant) begin
                s_info_q <= w_sel_info;
                s_id_q   <= w_sel_id;
                req_id_q <= {w_win_oh, w_sel_id};
            end
        end
    end

    assign s_req_valid     = (state_q == ST_SEND);
    assign s_req_info      = s_info_q;
    assign s_req_id        = s_id_q;
    assign req_wren        = req_wren_q;
    assign req_id          = req_id_q;
    assign outstanding_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_interconnect_crossbar_sreq_arbit.sv
// ============================================================================
// Module   : tb_axi_interconnect_crossbar_sreq_arbit
// Purpose  : Directed self-checking bench for the slave request arbiter
//            (NUM_MASTER=2, WIDTH_ID=4, WIDTH_REQINFO=64, NUM_OUTSTANDING=4).
//            Expected grant order follows AXI_IC_SREQ_FIXED_PRIO_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_interconnect_crossbar_sreq_arbit;

    logic         clk_sys = 1'b0;
    logic         rst_n;
    logic [127:0] m_req_info;
    logic [7:0]   m_req_id;
    logic [1:0]   m_req_valid;
    logic [1:0]   m_req_ready;
    logic [63:0]  s_req_info;
    logic [3:0]   s_req_id;
    logic         s_req_valid;
    logic         s_req_ready;
    logic         req_wren;
    logic [5:0]   req_id;
    logic         resp_done;
    logic [2:0]   outstanding_cnt;

    int checks = 0;
    int errors = 0;
    int ngrant;
    int nwr;
    logic [1:0] exp_g;

    always #5 clk_sys = ~clk_sys;

    axi_interconnect_crossbar_sreq_arbit #(
        .NUM_MASTER        (2),
        .WIDTH_ID          (4),
        .WIDTH_REQINFO     (64),
        .NUM_OUTSTANDING   (4),
        .WIDTH_OUTSTANDING (2),
        .U_DLY             (1)
    ) dut (
        .clk_sys         (clk_sys),
        .rst_n           (rst_n),
        .m_req_info      (m_req_info),
        .m_req_id        (m_req_id),
        .m_req_valid     (m_req_valid),
        .m_req_ready     (m_req_ready),
        .s_req_info      (s_req_info),
        .s_req_id        (s_req_id),
        .s_req_valid     (s_req_valid),
        .s_req_ready     (s_req_ready),
        .req_wren        (req_wren),
        .req_id          (req_id),
        .resp_done       (resp_done),
        .outstanding_cnt (outstanding_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        m_req_info  = '0;
        m_req_id    = '0;
        m_req_valid = 2'b11;
        s_req_ready = 1'b0;
        resp_done   = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        #1;
        chk("rst_m_req_ready", m_req_ready, 2'b00);
        chk("rst_s_req_valid", s_req_valid, 1'b0);
        chk("rst_s_req_info", s_req_info, 64'h0);
        chk("rst_s_req_id", s_req_id, 4'h0);
        chk("rst_req_wren", req_wren, 1'b0);
        chk("rst_req_id", req_id, 6'h0);
        chk("rst_cnt", outstanding_cnt, 3'd0);
        m_req_valid = 2'b00;
        rst_n       = 1'b1;
        step();

        // ---------------- single request from master 1 ----------------
        m_req_info  = {64'hA5, 64'h1111};
        m_req_id    = 8'h53;
        m_req_valid = 2'b10;
        #1;
        chk("single_ready", m_req_ready, 2'b10);
        step();
        chk("single_s_valid", s_req_valid, 1'b1);
        chk("single_s_info", s_req_info, 64'hA5);
        chk("single_s_id", s_req_id, 4'h5);
        chk("single_wren", req_wren, 1'b1);
        chk("single_req_id", req_id, 6'b10_0101);
        chk("single_cnt", outstanding_cnt, 3'd1);
        chk("single_send_noready", m_req_ready, 2'b00);
        m_req_valid = 2'b00;
        s_req_ready = 1'b1;
        step();
        chk("single_idle_valid", s_req_valid, 1'b0);
        chk("single_wren_pulse", req_wren, 1'b0);
        s_req_ready = 1'b0;
        resp_done   = 1'b1;
        step();
        resp_done   = 1'b0;
        chk("single_cnt_back", outstanding_cnt, 3'd0);

        // ---------------- round robin: 8 grants ----------------
        // Last winner was master 1, so master 0 comes next.
        m_req_valid = 2'b11;
        s_req_ready = 1'b1;
        for (int g = 0; g < 8; g++) begin
`ifdef AXI_IC_SREQ_FIXED_PRIO_EN
            exp_g = 2'b01;
`else
            exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
`endif
            #1;
            chk("rr_grant", m_req_ready, exp_g);
            step();
            chk("rr_queue_onehot", req_id[5:4], exp_g);
            resp_done = 1'b1;
            step();
            resp_done = 1'b0;
        end
        chk("rr_cnt_end", outstanding_cnt, 3'd0);

        // ---------------- credit limit ----------------
        ngrant = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (m_req_ready != 2'b00) ngrant++;
            step();
        end
        chk("credit_grants", ngrant, 4);
        #1;
        chk("credit_exhausted_ready", m_req_ready, 2'b00);
        chk("credit_cnt_max", outstanding_cnt, 3'd4);
        resp_done = 1'b1;
        #1;
        chk("credit_same_cycle_ready", m_req_ready, 2'b00);
        step();
        resp_done = 1'b0;
        #1;
        chk("credit_cnt_freed", outstanding_cnt, 3'd3);
        chk("credit_regrant", m_req_ready, 2'b01);
        step();
        chk("credit_cnt_refull", outstanding_cnt, 3'd4);
        ngrant = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (m_req_ready != 2'b00) ngrant++;
            step();
        end
        chk("credit_no_extra", ngrant, 0);

        // drain the four outstanding transactions, then one extra pulse
        m_req_valid = 2'b00;
        resp_done   = 1'b1;
        for (int c = 0; c < 4; c++) step();
        chk("drain_cnt", outstanding_cnt, 3'd0);
        step();
        resp_done   = 1'b0;
        chk("resp_at_zero_cnt", outstanding_cnt, 3'd0);

        // ---------------- simultaneous grant and resp_done ----------------
        m_req_valid = 2'b01;
        #1;
        chk("simul_grant_a", m_req_ready, 2'b01);
        step();
        step();
        #1;
        chk("simul_grant_b", m_req_ready, 2'b01);
        step();
        step();
        chk("simul_cnt_pre", outstanding_cnt, 3'd2);
        resp_done = 1'b1;
        #1;
        chk("simul_grant_c", m_req_ready, 2'b01);
        step();
        resp_done = 1'b0;
        chk("simul_cnt_hold", outstanding_cnt, 3'd2);
        m_req_valid = 2'b00;
        step();

        // ---------------- slave backpressure ----------------
        s_req_ready = 1'b0;
        m_req_info  = {64'hBEEF, 64'h1234};
        m_req_id    = 8'h9C;
        m_req_valid = 2'b10;
        #1;
        chk("bp_grant", m_req_ready, 2'b10);
        step();
        m_req_valid = 2'b11;
        nwr = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (req_wren) nwr++;
            chk("bp_s_valid", s_req_valid, 1'b1);
            chk("bp_s_info", s_req_info, 64'hBEEF);
            chk("bp_s_id", s_req_id, 4'h9);
            chk("bp_no_grant", m_req_ready, 2'b00);
            step();
        end
        chk("bp_wren_once", nwr, 1);
        chk("bp_cnt", outstanding_cnt, 3'd3);

        // ---------------- reset mid-SEND ----------------
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_s_valid", s_req_valid, 1'b0);
        chk("mrst_s_info", s_req_info, 64'h0);
        chk("mrst_s_id", s_req_id, 4'h0);
        chk("mrst_wren", req_wren, 1'b0);
        chk("mrst_req_id", req_id, 6'h0);
        chk("mrst_cnt", outstanding_cnt, 3'd0);
        chk("mrst_ready", m_req_ready, 2'b00);
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_grant", m_req_ready, 2'b01);
        step();
        chk("post_rst_s_id", s_req_id, 4'hC);
        chk("post_rst_req_id", req_id, 6'b01_1100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi_interconnect_crossbar_sreq_arbit.md
# axi_interconnect_crossbar_sreq_arbit

Request-side arbiter for one slave port of the AXI interconnect crossbar. It shares the slave's AR or AW address channel between NUM_MASTER requesters. Each accepted request is forwarded through a registered output stage. At the same time the block pushes the request's routing tag into the slave port's response-ordering queue and limits in-flight transactions to NUM_OUTSTANDING.

## Interface
- NUM_MASTER, 2, number of requesting masters (1 ~ 4)
- WIDTH_ID, 4, AXI ID width carried with each request (>= 1)
- WIDTH_REQINFO, 64, packed address-channel payload width (addr/len/size/burst/...)
- NUM_OUTSTANDING, 4, maximum in-flight transactions on this slave port (1 ~ 16)
- WIDTH_OUTSTANDING, LOG2(NUM_OUTSTANDING), width of the outstanding counter
- U_DLY, 1, register update delay
- clk_sys  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- m_req_info  in  NUM_MASTER*WIDTH_REQINFO  payload of master i at slice [i*WIDTH_REQINFO +: WIDTH_REQINFO]
- m_req_id  in  NUM_MASTER*WIDTH_ID  ID of master i at slice [i*WIDTH_ID +: WIDTH_ID]
- m_req_valid  in  NUM_MASTER  request valid per master
- m_req_ready  out  NUM_MASTER  one-hot grant/accept; at most one bit high
- s_req_info  out  WIDTH_REQINFO  registered payload to slave
- s_req_id  out  WIDTH_ID  registered ID to slave
- s_req_valid  out  1  slave request valid
- s_req_ready  in  1  slave accepts
- req_wren  out  1  one-cycle push into response-ordering queue
- req_id  out  NUM_MASTER+WIDTH_ID  queue entry: {grant one-hot, ID}
- resp_done  in  1  one pulse per completed transaction (last response beat handshaken)
- outstanding_cnt  out  WIDTH_OUTSTANDING+1  current in-flight count

## Operation
- FSM states:
  - IDLE: output register empty.
  - SEND: s_req_valid=1, waiting for s_req_ready.
- Grant condition in IDLE: |m_req_valid and credit_ok, where credit_ok = (outstanding_cnt < NUM_OUTSTANDING).
- Arbitration is combinational in IDLE. Round-robin search starts at last_grant+1 mod NUM_MASTER; the winner g gets m_req_ready[g]=1 that cycle.
- m_req_ready is 0 in SEND, when credit is exhausted, and during reset.
- On grant:
  - Register m_req_info/m_req_id slices of g into s_req_info/s_req_id.
  - Set last_grant<=g and move to SEND.
  - Assert req_wren for exactly one cycle with req_id={onehot(g), m_req_id slice g}.
- In SEND, s_req_info/s_req_id are held stable. On s_req_valid&s_req_ready, move to IDLE; no grant occurs in that same cycle.
- outstanding_cnt:
  - +1 on grant; -1 on resp_done; unchanged when both occur in the same cycle.
  - resp_done while outstanding_cnt==0 is ignored; the count saturates at 0.
  - The count never exceeds NUM_OUTSTANDING.
- NUM_MASTER==1: the arbiter degenerates to a pass-through grant of master 0; the FSM and credit logic are unchanged.

## Timing
- Reset values:
  - s_req_valid=0, s_req_info=0, s_req_id=0
  - req_wren=0, req_id=0
  - outstanding_cnt=0, state=IDLE
  - last_grant=NUM_MASTER-1, so master 0 has first priority
- Latency: grant in cycle N. s_req_valid, req_wren and req_id are valid in cycle N+1. req_wren is never asserted later than s_req_valid first rises, so the queue entry exists before any response can return.
- Throughput: at most one request every 2 cycles; this is the back-to-back ceiling when s_req_ready=1.
- Credit freed by resp_done in cycle N permits a grant in cycle N+1, not in cycle N.
- A master that drops m_req_valid without a grant loses nothing. Payload and ID are sampled only in the grant cycle.
- Reset asserted mid-transaction clears the FSM, counter and output register immediately. Lost queue entries are the system's responsibility; the response path is reset together with this block.

## Configuration
- AXI_IC_SREQ_FIXED_PRIO_EN defined: fixed priority, lowest master index wins. last_grant is not used for arbitration.
- AXI_IC_SREQ_FIXED_PRIO_EN undefined (default): round-robin as described above.
- All other behaviour is identical in both configurations.

## Test plan
- Single request: NUM_MASTER=2, master 1 valid with ID=4'h5, info=64'hA5 -> m_req_ready=2'b10 in cycle N. In N+1: s_req_valid=1, s_req_info=64'hA5, s_req_id=5, req_wren pulse, req_id=6'b10_0101, outstanding_cnt=1.
- Round-robin fairness: both masters continuously valid, s_req_ready=1, resp_done returned each grant -> grants alternate 0,1,0,1 for 8 grants. With AXI_IC_SREQ_FIXED_PRIO_EN the grants are 0,0,0,0.
- Credit limit: NUM_OUTSTANDING=4, no resp_done -> exactly 4 grants, then m_req_ready=0 and outstanding_cnt=4. One resp_done pulse -> exactly one further grant on the following cycle.
- Slave backpressure: s_req_ready=0 for 5 cycles after grant -> s_req_valid, s_req_info and s_req_id stay stable. No second grant occurs and req_wren pulses exactly once.
- Simultaneous events: grant and resp_done in the same cycle at outstanding_cnt=2 -> count stays 2. resp_done at count 0 -> count stays 0.
- Reset mid-SEND: rst_n low while s_req_valid=1 -> all outputs zero immediately. After release, the first grant goes to master 0.
